// File: rtl/data_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl_pkg: shared types for the memory-stage bus adapter | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package data_mem_ctrl_pkg;

  typedef logic [31:0] word;

  typedef enum logic {
    MEM_READ_EN  = 1'b0,
    MEM_WRITE_EN = 1'b1
  } mem_en_t;

  typedef struct packed {
    logic    mem_enable;
    mem_en_t mem_en;
    word     address;
    word     data_in;
  } data_memory_interface_t;

endpackage

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl: write-unit request to req/ack bus adapter with stall and
// fault reporting | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  data_memory_interface_t mem_sig,
  output word                    mem_data_out,
  output logic                   stall,
  output logic                   mem_fault,
  output logic [1:0]             fault_cause,
  output logic                   bus_req,
  output logic                   bus_we,
  output word                    bus_addr,
  output word                    bus_wdata,
  input  logic                   bus_ack,
  input  logic                   bus_err,
  input  word                    bus_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_BUSY = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  localparam logic [1:0] c_CAUSE_NONE  = 2'b00;
  localparam logic [1:0] c_CAUSE_ALIGN = 2'b01;
  localparam logic [1:0] c_CAUSE_BUS   = 2'b10;
  localparam logic [1:0] c_CAUSE_TMO   = 2'b11;

  localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  word              addr_q, addr_d;
  word              wdata_q, wdata_d;
  word              data_q, data_d;
  logic [1:0]       cause_q, cause_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    cause_d = cause_q;

    case (state_q)
      c_ST_IDLE: begin
        if (mem_sig.mem_enable) begin
          if (mem_sig.address[1:0] != 2'b00) begin
            data_d  = '0;
            cause_d = c_CAUSE_ALIGN;
            state_d = c_ST_DONE;
          end else begin
            addr_d  = mem_sig.address;
            wdata_d = mem_sig.data_in;
            we_d    = (mem_sig.mem_en == MEM_WRITE_EN);
            cnt_d   = '0;
            state_d = c_ST_BUSY;
          end
        end
      end

      c_ST_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // An ack in the final allowed cycle still completes the access.
        if (bus_ack) begin
          state_d = c_ST_DONE;
          if (bus_err) begin
            data_d  = '0;
            cause_d = c_CAUSE_BUS;
          end else begin
            data_d  = we_q ? '0 : bus_rdata;
            cause_d = c_CAUSE_NONE;
          end
        end else if (cnt_q == c_TMO_LAST) begin
          data_d  = '0;
          cause_d = c_CAUSE_TMO;
          state_d = c_ST_DONE;
        end
      end

      c_ST_DONE: state_d = c_ST_IDLE;

      default: state_d = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      cause_q <= c_CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      cause_q <= cause_d;
    end
  end

  assign stall        = ((state_q == c_ST_IDLE) && mem_sig.mem_enable) || (state_q == c_ST_BUSY);
  assign bus_req      = (state_q == c_ST_BUSY);
  assign bus_we       = we_q;
  assign bus_addr     = addr_q;
  assign bus_wdata    = wdata_q;
  assign mem_data_out = (state_q == c_ST_DONE) ? data_q : '0;
  assign mem_fault    = (state_q == c_ST_DONE) && (cause_q != c_CAUSE_NONE);
  assign fault_cause  = cause_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl: scoreboard bench for data_mem_ctrl (default and
// TIMEOUT_CYCLES=4 instances) | rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  typedef struct {
    word        data;
    logic       fault;
    logic [1:0] cause;
    int         req;
    int         stl;
    int         acks;
    logic       we;
    word        addr;
    word        wdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  data_memory_interface_t msig [2];
  word        mdo    [2];
  logic       stall  [2];
  logic       mflt   [2];
  logic [1:0] fc     [2];
  logic       breq   [2];
  logic       bwe    [2];
  word        baddr  [2];
  word        bwdata [2];
  logic       back   [2];
  logic       berr   [2];
  word        brdata [2];

  int   cfg_delay [2];
  logic cfg_err   [2];
  word  cfg_rdata [2];
  bit   cfg_noack [2];
  int   scnt      [2];

  int         mreq    [2];
  int         mstl    [2];
  int         macks   [2];
  bit         mstable [2];
  logic [1:0] lcause  [2];

  exp_t q0[$];
  exp_t q1[$];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.TIMEOUT_CYCLES(255)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mem_sig(msig[0]), .mem_data_out(mdo[0]),
    .stall(stall[0]), .mem_fault(mflt[0]), .fault_cause(fc[0]),
    .bus_req(breq[0]), .bus_we(bwe[0]), .bus_addr(baddr[0]), .bus_wdata(bwdata[0]),
    .bus_ack(back[0]), .bus_err(berr[0]), .bus_rdata(brdata[0])
  );

  data_mem_ctrl #(.TIMEOUT_CYCLES(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mem_sig(msig[1]), .mem_data_out(mdo[1]),
    .stall(stall[1]), .mem_fault(mflt[1]), .fault_cause(fc[1]),
    .bus_req(breq[1]), .bus_we(bwe[1]), .bus_addr(baddr[1]), .bus_wdata(bwdata[1]),
    .bus_ack(back[1]), .bus_err(berr[1]), .bus_rdata(brdata[1])
  );

  task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL dut%0d %s: got 0x%08h, want 0x%08h", d, name, act, exp);
  endtask

  // Present one request, queue its expected outcome, and hold it until DONE.
  task automatic issue(input int d, input logic we, input word addr, input word wdata,
                       input int delay, input logic err, input word rdata, input bit noack,
                       input word e_data, input logic [1:0] e_cause,
                       input int e_req, input int e_stl, input int e_acks);
    exp_t e;
    int   n;
    cfg_delay[d] = delay;
    cfg_err[d]   = err;
    cfg_rdata[d] = rdata;
    cfg_noack[d] = noack;
    e.data  = e_data;
    e.fault = (e_cause != 2'b00);
    e.cause = e_cause;
    e.req   = e_req;
    e.stl   = e_stl;
    e.acks  = e_acks;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    msig[d].mem_enable = 1'b1;
    msig[d].mem_en     = we ? MEM_WRITE_EN : MEM_READ_EN;
    msig[d].address    = addr;
    msig[d].data_in    = wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall[d] && n < 60);
    if (stall[d]) begin
      n_total++;
      $display("FAIL dut%0d done_wait: still stalled after %0d cycles, want DONE", d, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d, input int cycles);
    msig[d].mem_enable = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Bus slave: acks after cfg_delay BUSY cycles, one strobe per request.
  initial begin
    for (int d = 0; d < 2; d++) begin
      back[d] = 1'b0; berr[d] = 1'b0; brdata[d] = '0; scnt[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        brdata[d] = cfg_rdata[d];
        if (!breq[d]) begin
          back[d] = 1'b0; berr[d] = 1'b0; scnt[d] = 0;
        end else begin
          if (back[d]) begin
            back[d] = 1'b0; berr[d] = 1'b0;
          end else if (!cfg_noack[d] && scnt[d] == cfg_delay[d]) begin
            back[d] = 1'b1; berr[d] = cfg_err[d];
          end
          scnt[d]++;
        end
      end
    end
  end

  // Monitor: accumulates per-access observations and scores them at DONE.
  initial begin
    exp_t e;
    bit   has;
    bit   done;
    for (int d = 0; d < 2; d++) begin
      mreq[d] = 0; mstl[d] = 0; macks[d] = 0; mstable[d] = 1'b1; lcause[d] = 2'b00;
    end
    forever begin
      @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          mreq[d] = 0; mstl[d] = 0; macks[d] = 0; mstable[d] = 1'b1; lcause[d] = 2'b00;
        end else begin
          if (d == 0) begin
            has = (q0.size() != 0);
            if (has) e = q0[0];
          end else begin
            has = (q1.size() != 0);
            if (has) e = q1[0];
          end
          done = msig[d].mem_enable && !stall[d];
          if (stall[d]) mstl[d]++;
          if (breq[d]) begin
            mreq[d]++;
            if (back[d]) macks[d]++;
            if (has && (bwe[d] !== e.we || baddr[d] !== e.addr || bwdata[d] !== e.wdata))
              mstable[d] = 1'b0;
          end
          if (done) begin
            if (!has) begin
              n_total++;
              $display("FAIL dut%0d unexpected_done: got DONE, want no pending access", d);
            end else begin
              if (d == 0) e = q0.pop_front();
              else        e = q1.pop_front();
              chk(d, "data_out",     mdo[d],                   e.data);
              chk(d, "mem_fault",    32'(mflt[d]),             32'(e.fault));
              chk(d, "fault_cause",  32'(fc[d]),               32'(e.cause));
              chk(d, "req_cycles",   32'(mreq[d]),             32'(e.req));
              chk(d, "stall_cycles", 32'(mstl[d]),             32'(e.stl));
              chk(d, "handshakes",   32'(macks[d]),            32'(e.acks));
              chk(d, "bus_stable",   32'(mstable[d]),          32'd1);
              lcause[d] = e.cause;
            end
            mreq[d] = 0; mstl[d] = 0; macks[d] = 0; mstable[d] = 1'b1;
          end else begin
            chk(d, "idle_data",  mdo[d],        32'd0);
            chk(d, "idle_fault", 32'(mflt[d]),  32'd0);
            chk(d, "cause_hold", 32'(fc[d]),    32'(lcause[d]));
          end
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      msig[d] = '0;
      cfg_delay[d] = 0; cfg_err[d] = 1'b0; cfg_rdata[d] = '0; cfg_noack[d] = 1'b0;
    end
    rst_n = 1'b0;
    #12;
    chk(0, "rst_bus_req",  32'(breq[0]),  32'd0);
    chk(0, "rst_bus_we",   32'(bwe[0]),   32'd0);
    chk(0, "rst_bus_addr", baddr[0],      32'd0);
    chk(0, "rst_wdata",    bwdata[0],     32'd0);
    chk(0, "rst_data_out", mdo[0],        32'd0);
    chk(0, "rst_cause",    32'(fc[0]),    32'd0);
    chk(0, "rst_stall",    32'(stall[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load with immediate ack.
    issue(0, 1'b0, 32'h0000_0100, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 2'b00, 1, 2, 1);
    idle(0, 1);
    // Store with four wait states.
    issue(0, 1'b1, 32'h0000_0020, 32'h1234_5678, 4, 1'b0, 32'h55AA_55AA, 1'b0, 32'h0, 2'b00, 5, 6, 1);
    idle(0, 2);
    // Back-to-back load then store.
    issue(0, 1'b0, 32'h0000_0040, 32'h0, 1, 1'b0, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 2'b00, 2, 3, 1);
    issue(0, 1'b1, 32'h0000_0044, 32'hA5A5_A5A5, 0, 1'b0, 32'h1111_2222, 1'b0, 32'h0, 2'b00, 1, 2, 1);
    idle(0, 1);
    // Misaligned load.
    issue(0, 1'b0, 32'h0000_0102, 32'h0, 0, 1'b0, 32'h9999_9999, 1'b0, 32'h0, 2'b01, 0, 1, 0);
    idle(0, 1);
    // Bus error.
    issue(0, 1'b0, 32'h0000_0200, 32'h0, 2, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0, 2'b10, 3, 4, 1);
    idle(0, 1);

    // Reset during BUSY abandons the access.
    cfg_noack[0]          = 1'b1;
    msig[0].mem_enable    = 1'b1;
    msig[0].mem_en        = MEM_READ_EN;
    msig[0].address       = 32'h0000_0400;
    msig[0].data_in       = 32'h0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk(0, "midrst_bus_req",  32'(breq[0]), 32'd0);
    chk(0, "midrst_fault",    32'(mflt[0]), 32'd0);
    chk(0, "midrst_data_out", mdo[0],       32'd0);
    chk(0, "midrst_cause",    32'(fc[0]),   32'd0);
    msig[0].mem_enable = 1'b0;
    #1;
    chk(0, "midrst_stall",    32'(stall[0]), 32'd0);
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(0, 1'b0, 32'h0000_0300, 32'h0, 0, 1'b0, 32'h1357_9BDF, 1'b0, 32'h1357_9BDF, 2'b00, 1, 2, 1);
    idle(0, 1);

    // TIMEOUT_CYCLES = 4: never acked, then acked on the last allowed cycle.
    issue(1, 1'b0, 32'h0000_0500, 32'h0, 0, 1'b0, 32'h7777_7777, 1'b1, 32'h0, 2'b11, 4, 5, 0);
    idle(1, 1);
    issue(1, 1'b0, 32'h0000_0504, 32'h0, 3, 1'b0, 32'h2468_ACE0, 1'b0, 32'h2468_ACE0, 2'b00, 4, 5, 1);
    idle(1, 3);

    chk(0, "queue_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200us, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Sequential bus adapter that sits directly downstream of the memory stage's write unit. It takes the combinational `data_memory_interface_t` request the write unit drives and turns it into a request/acknowledge transaction on the external data bus. It stalls the pipeline until the transaction completes, then returns load data on `mem_data_out`. Misaligned accesses, bus errors and timeouts are reported as a one-cycle fault.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles `bus_req` stays high without `bus_ack` before the access is aborted. Must be ≥ 1.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_sig`  in  `data_memory_interface_t`  request from the write unit: `mem_enable`, `mem_en` (`MEM_READ_EN`/`MEM_WRITE_EN`), `address`, `data_in`.
- `mem_data_out`  out  `word`  load data returned to the write unit.
- `stall`  out  1  holds the pipeline; the memory stage and everything upstream freeze while high.
- `mem_fault`  out  1  one-cycle fault pulse.
- `fault_cause`  out  2  00 none, 01 misaligned, 10 bus error, 11 timeout.
- `bus_req`  out  1  bus request.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  `word`  bus address.
- `bus_wdata`  out  `word`  store data.
- `bus_ack`  in  1  slave completion strobe.
- `bus_err`  in  1  slave error; qualified by `bus_ack`.
- `bus_rdata`  in  `word`  read data; qualified by `bus_ack`.

## Operation
States: IDLE, BUSY, DONE.

**IDLE**
- `mem_sig.mem_enable` = 0: stay in IDLE; `stall` = 0.
- `mem_enable` = 1 and `address[1:0]` ≠ 0: go to DONE with cause 01. No bus transaction is started.
- `mem_enable` = 1 and aligned:
  - Latch `address`, `data_in` and `we` (`we` = `mem_en == MEM_WRITE_EN`) into `bus_addr`, `bus_wdata`, `bus_we`.
  - Set `bus_req`, clear the timeout counter, go to BUSY.

**BUSY**
- `bus_req` = 1; the counter increments each cycle.
- `bus_ack` = 1, `bus_err` = 0: capture `bus_rdata` if this is a read (else capture 0); go to DONE with cause 00.
- `bus_ack` = 1, `bus_err` = 1: data 0; go to DONE with cause 10.
- `bus_ack` = 0 and counter = `TIMEOUT_CYCLES`−1: data 0; go to DONE with cause 11.
- If ack and timeout occur in the same cycle, the ack wins.

**DONE**
- `stall` = 0.
- `mem_data_out` = captured data.
- `mem_fault` = 1 if cause ≠ 00.
- Unconditionally return to IDLE. The pipeline advances at the end of this cycle, so a new request is seen in the following IDLE cycle.

**Outputs**
- `stall` is combinational: 1 in IDLE when `mem_enable` = 1, 1 in BUSY, 0 otherwise. The requesting instruction never advances before DONE.
- `mem_data_out` = 0 outside DONE, and 0 in DONE for stores and faults.
- `fault_cause` is registered on DONE entry and holds its value until the next DONE entry.
- `bus_addr`, `bus_wdata` and `bus_we` are stable for the entire time `bus_req` is high. They keep their last values afterwards.
- `bus_ack` is ignored outside BUSY.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`.

## Timing
- Reset values (asynchronous, on `rst_n` low): state IDLE; `bus_req`, `bus_we`, `mem_fault` = 0; `bus_addr`, `bus_wdata`, `mem_data_out`, data register = 0; `fault_cause` = 00; counter = 0. `stall` follows its combinational rule from IDLE.
- Reset mid-BUSY: `bus_req` drops immediately and the transaction is abandoned. The slave must tolerate this.
- Bus handshake: `bus_req` rises the cycle after the IDLE accept. It falls in the cycle after `bus_ack` is sampled high. The slave must not assert `bus_ack` twice for one request.
- Minimum latency, aligned access, ack in the first BUSY cycle: 3 cycles from `mem_enable` to the DONE cycle (IDLE, BUSY, DONE), of which 2 are stalled.
- Misaligned access: 2 cycles (IDLE, DONE).
- Timeout: `bus_req` is high for exactly `TIMEOUT_CYCLES` cycles, then DONE.
- Back-to-back memory ops: minimum one DONE cycle between successive requests. Throughput is at most one access per 3 cycles.

## Test plan
- **Load, immediate ack.** Load at address 0x100; slave acks in the first BUSY cycle with `bus_rdata` = 0xDEADBEEF. Required: `stall` high for 2 cycles, `bus_we` = 0, `bus_addr` = 0x100; DONE shows `mem_data_out` = 0xDEADBEEF, `mem_fault` = 0, `fault_cause` = 00.
- **Store, 4 wait states.** Store of 0x12345678 to 0x20; ack after 4 cycles. Required: `bus_req` high for 5 cycles with `bus_we` = 1 and `bus_wdata` = 0x12345678 stable throughout; `mem_data_out` = 0; `stall` high for 6 cycles.
- **Misaligned load.** Load at 0x102. Required: no `bus_req` pulse; DONE on the 2nd cycle with `mem_fault` = 1, `fault_cause` = 01, `mem_data_out` = 0.
- **Bus error, then timeout.** Load where the slave returns ack + err; then, with `TIMEOUT_CYCLES` = 4, a load that is never acked. Required: first access gives fault cause 10 with data 0. Second access holds `bus_req` for exactly 4 cycles, then fault cause 11. With ack arriving on the 4th cycle instead: success with cause 00.
- **Back-to-back.** Load followed directly by a store. Required: the second request is accepted in the IDLE cycle right after DONE, and each access receives exactly one bus handshake.
- **Reset mid-transaction.** Assert `rst_n` low during BUSY. Required: `bus_req`, `mem_fault` and `mem_data_out` go to 0 immediately, `fault_cause` = 00, state IDLE. A fresh load after reset release completes normally.
